// File: rtl/rob_pkg.sv
// Shared types and default sizing for the reorder queue: entry kinds,
// control-state encoding and the per-entry control record.
package rob_pkg;

    localparam int ROB_DEPTH     = 32;
    localparam int ROB_XLEN      = 32;
    localparam int ROB_TAG_W     = 8;
    localparam int ROB_CDB_PORTS = 2;
    localparam int ROB_COMMIT_W  = 2;

    typedef enum logic [1:0] {
        KIND_REG    = 2'd0,
        KIND_STORE  = 2'd1,
        KIND_BRANCH = 2'd2,
        KIND_HALT   = 2'd3
    } rob_kind_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HALTED = 2'd2
    } rob_state_e;

    // Control half of an entry; tag/value/address live in parameter-sized arrays.
    typedef struct packed {
        logic      valid;
        logic      done;
        logic      mispredict;
        rob_kind_e kind;
        logic [4:0] rd;
    } rob_entry_t;

    // An entry of this shape closes the commit group it lands in.
    function automatic logic ends_commit(input rob_entry_t e);
        return (e.kind == KIND_HALT) || ((e.kind == KIND_BRANCH) && e.mispredict);
    endfunction

endpackage

// File: rtl/reorder_queue_if.sv
// Dispatch, result-broadcast, lookup and commit bundle of the reorder queue.
// Handshake: an entry is accepted on a rising edge where disp_valid && disp_ready.
interface reorder_queue_if
    import rob_pkg::*;
#(
    parameter int DEPTH     = ROB_DEPTH,
    parameter int XLEN      = ROB_XLEN,
    parameter int TAG_W     = ROB_TAG_W,
    parameter int CDB_PORTS = ROB_CDB_PORTS,
    parameter int COMMIT_W  = ROB_COMMIT_W
);
    localparam int AW = $clog2(DEPTH);

    logic                      disp_valid;
    logic                      disp_ready;
    logic [1:0]                disp_kind;
    logic [4:0]                disp_rd;
    logic [TAG_W-1:0]          disp_tag;
    logic [XLEN-1:0]           disp_addr;
    logic [AW-1:0]             disp_idx;

    logic [CDB_PORTS-1:0]      cdb_valid;
    logic [CDB_PORTS*TAG_W-1:0] cdb_tag;
    logic [CDB_PORTS*XLEN-1:0] cdb_value;
    logic [CDB_PORTS-1:0]      cdb_mispredict;

    logic [AW-1:0]             rd_idx;
    logic                      rd_ready;
    logic [XLEN-1:0]           rd_value;

    logic [COMMIT_W-1:0]       cmt_valid;
    logic [COMMIT_W*2-1:0]     cmt_kind;
    logic [COMMIT_W*5-1:0]     cmt_rd;
    logic [COMMIT_W*XLEN-1:0]  cmt_value;
    logic [COMMIT_W*XLEN-1:0]  cmt_addr;

    logic                      flush;
    logic                      halted;
    rob_state_e                dbg_state;

    modport master (
        output disp_valid, disp_kind, disp_rd, disp_tag, disp_addr,
        output cdb_valid, cdb_tag, cdb_value, cdb_mispredict, rd_idx,
        input  disp_ready, disp_idx, rd_ready, rd_value,
        input  cmt_valid, cmt_kind, cmt_rd, cmt_value, cmt_addr,
        input  flush, halted, dbg_state
    );

    modport slave (
        input  disp_valid, disp_kind, disp_rd, disp_tag, disp_addr,
        input  cdb_valid, cdb_tag, cdb_value, cdb_mispredict, rd_idx,
        output disp_ready, disp_idx, rd_ready, rd_value,
        output cmt_valid, cmt_kind, cmt_rd, cmt_value, cmt_addr,
        output flush, halted, dbg_state
    );

endinterface

// File: rtl/rob_cdb_match.sv
// Per-entry result capture: compares one pending tag against every broadcast
// channel; the lowest-numbered matching channel supplies value and mispredict.
module rob_cdb_match #(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 8,
    parameter int CDB_PORTS = 2
) (
    input  logic                       pending,
    input  logic [TAG_W-1:0]           tag,
    input  logic [CDB_PORTS-1:0]       cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0]  cdb_value,
    input  logic [CDB_PORTS-1:0]       cdb_mispredict,
    output logic                       hit,
    output logic [XLEN-1:0]            value,
    output logic                       mispredict
);

    // Scan from the highest channel down so the lowest match is written last.
    always_comb begin
        hit        = 1'b0;
        value      = '0;
        mispredict = 1'b0;
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (pending && cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == tag)) begin
                hit        = 1'b1;
                value      = cdb_value[p*XLEN +: XLEN];
                mispredict = cdb_mispredict[p];
            end
        end
    end

endmodule

// File: rtl/reorder_queue.sv
// In-order commit reorder queue with multi-port result capture, mispredict
// flush and sticky halt. Define ROB_BYPASS_EN to forward same-cycle results to lookups.
module reorder_queue
    import rob_pkg::*;
#(
    parameter int DEPTH     = ROB_DEPTH,
    parameter int XLEN      = ROB_XLEN,
    parameter int TAG_W     = ROB_TAG_W,
    parameter int CDB_PORTS = ROB_CDB_PORTS,
    parameter int COMMIT_W  = ROB_COMMIT_W
) (
    input  logic          CLOCK_50,
    input  logic          RSTN_N,
    reorder_queue_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(COMMIT_W + 1);

    logic [AW:0]      head, tail;
    rob_entry_t       ent     [DEPTH];
    logic [TAG_W-1:0] tag_q   [DEPTH];
    logic [XLEN-1:0]  value_q [DEPTH];
    logic [XLEN-1:0]  addr_q  [DEPTH];
    rob_state_e       state, state_nxt;

    logic             full, accept;
    logic [AW-1:0]    tail_idx;

    logic [DEPTH-1:0] hit, hit_mp;
    logic [XLEN-1:0]  hit_value [DEPTH];

    logic [COMMIT_W-1:0] lane_v;
    logic [AW-1:0]       lane_slot [COMMIT_W];
    logic [LW-1:0]       commit_cnt;
    logic                lane_open, stop_mp, stop_halt;

    // The extra wrap bit distinguishes full from empty when indices coincide.
    assign tail_idx       = tail[AW-1:0];
    assign full           = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);
    assign bus.disp_ready = !full && (state == ST_RUN);
    assign accept         = bus.disp_valid && bus.disp_ready;
    assign bus.disp_idx   = tail_idx;
    assign bus.flush      = (state == ST_FLUSH);
    assign bus.halted     = (state == ST_HALTED);
    assign bus.dbg_state  = state;

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        rob_cdb_match #(
            .XLEN      (XLEN),
            .TAG_W     (TAG_W),
            .CDB_PORTS (CDB_PORTS)
        ) u_match (
            .pending        (ent[i].valid && !ent[i].done),
            .tag            (tag_q[i]),
            .cdb_valid      (bus.cdb_valid),
            .cdb_tag        (bus.cdb_tag),
            .cdb_value      (bus.cdb_value),
            .cdb_mispredict (bus.cdb_mispredict),
            .hit            (hit[i]),
            .value          (hit_value[i]),
            .mispredict     (hit_mp[i])
        );
    end

    // Commit lanes: a contiguous run of done entries from head, closed after
    // the first mispredicted branch or halt. Nothing commits unless running.
    always_comb begin
        lane_v        = '0;
        commit_cnt    = '0;
        stop_mp       = 1'b0;
        stop_halt     = 1'b0;
        lane_open     = (state == ST_RUN);
        bus.cmt_valid = '0;
        bus.cmt_kind  = '0;
        bus.cmt_rd    = '0;
        bus.cmt_value = '0;
        bus.cmt_addr  = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            lane_slot[k] = head[AW-1:0] + AW'(k);
            if (lane_open && ent[lane_slot[k]].valid && ent[lane_slot[k]].done) begin
                lane_v[k]                    = 1'b1;
                commit_cnt                   = commit_cnt + LW'(1);
                bus.cmt_kind[k*2 +: 2]       = ent[lane_slot[k]].kind;
                bus.cmt_rd[k*5 +: 5]         = ent[lane_slot[k]].rd;
                bus.cmt_value[k*XLEN +: XLEN] = value_q[lane_slot[k]];
                bus.cmt_addr[k*XLEN +: XLEN]  = addr_q[lane_slot[k]];
                if (ent[lane_slot[k]].kind == KIND_HALT) begin
                    stop_halt = 1'b1;
                end else if (ends_commit(ent[lane_slot[k]])) begin
                    stop_mp = 1'b1;
                end
                if (ends_commit(ent[lane_slot[k]])) begin
                    lane_open = 1'b0;
                end
            end else begin
                lane_open = 1'b0;
            end
        end
        bus.cmt_valid = lane_v;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (stop_halt) begin
                    state_nxt = ST_HALTED;
                end else if (stop_mp) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH:  state_nxt = ST_RUN;
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
        if (!RSTN_N) begin
            state <= ST_RUN;
            head  <= '0;
            tail  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (stop_mp) begin
                // Squash everything younger than the committing branch.
                head <= '0;
                tail <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    ent[i] <= '0;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (hit[i]) begin
                        ent[i].done       <= 1'b1;
                        ent[i].mispredict <= hit_mp[i];
                    end
                end
                for (int k = 0; k < COMMIT_W; k++) begin
                    if (lane_v[k]) begin
                        ent[lane_slot[k]].valid <= 1'b0;
                        ent[lane_slot[k]].done  <= 1'b0;
                    end
                end
                head <= head + (AW+1)'(commit_cnt);
                if (accept) begin
                    ent[tail_idx].valid      <= 1'b1;
                    ent[tail_idx].done       <= (bus.disp_tag == '0) ||
                                                (rob_kind_e'(bus.disp_kind) == KIND_HALT);
                    ent[tail_idx].mispredict <= 1'b0;
                    ent[tail_idx].kind       <= rob_kind_e'(bus.disp_kind);
                    ent[tail_idx].rd         <= bus.disp_rd;
                    tail                     <= tail + (AW+1)'(1);
                end
            end
        end
    end

    // Payload storage needs no reset; validity is tracked in ent[].
    always_ff @(posedge CLOCK_50) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (hit[i]) begin
                value_q[i] <= hit_value[i];
            end
        end
        if (accept) begin
            tag_q[tail_idx]   <= bus.disp_tag;
            value_q[tail_idx] <= '0;
            addr_q[tail_idx]  <= bus.disp_addr;
        end
    end

    always_comb begin
        bus.rd_ready = ent[bus.rd_idx].done;
        bus.rd_value = value_q[bus.rd_idx];
`ifdef ROB_BYPASS_EN
        if (hit[bus.rd_idx]) begin
            bus.rd_ready = 1'b1;
            bus.rd_value = hit_value[bus.rd_idx];
        end
`endif
    end

endmodule
